// File: rtl/wb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_pkg                                                                 |
// | Shared widths, arbiter FSM encoding and write-request bundle.          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_mul_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_mul_queue                                                           |
// | Multiplier result FIFO with per-entry valid bit and address kill port. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module wb_mul_queue #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int Q_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rsta_n,
  input  logic                       push_i,
  input  logic                       push_kill_i,
  input  logic [ADDR_W-1:0]          push_waddr_i,
  input  logic [DATA_W-1:0]          push_wdata_i,
  input  logic                       pop_i,
  input  logic                       kill_i,
  input  logic [ADDR_W-1:0]          kill_addr_i,
  output logic [ADDR_W-1:0]          head_waddr_o,
  output logic [DATA_W-1:0]          head_wdata_o,
  output logic                       head_valid_o,
  output logic [$clog2(Q_DEPTH):0]   count_o
);
  import wb_pkg::*;

  localparam int C_PTR_W = $clog2(Q_DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;

  logic [ADDR_W-1:0]  addr_q [Q_DEPTH];
  logic [DATA_W-1:0]  data_q [Q_DEPTH];
  logic [Q_DEPTH-1:0] vld_q;
  logic [C_PTR_W-1:0] wr_ptr_q;
  logic [C_PTR_W-1:0] rd_ptr_q;
  logic [C_CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rsta_n) begin
    if (!rsta_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // The slot being written is never occupied, so a push overrides any kill on it.
      for (int i = 0; i < Q_DEPTH; i++) begin
        if (push_i && (wr_ptr_q == C_PTR_W'(i))) begin
          vld_q[i]  <= !push_kill_i;
          addr_q[i] <= push_waddr_i;
          data_q[i] <= push_wdata_i;
        end else if (kill_i && (addr_q[i] == kill_addr_i)) begin
          vld_q[i] <= 1'b0;
        end
      end
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + C_CNT_W'(push_i) - C_CNT_W'(pop_i);
    end
  end

  assign head_waddr_o = addr_q[rd_ptr_q];
  assign head_wdata_o = data_q[rd_ptr_q];
  assign head_valid_o = vld_q[rd_ptr_q] && (count_q != '0);
  assign count_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_port_arbiter                                                        |
// | Shares the register-file write port between MEM/WB and mul results.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int Q_DEPTH  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       rsta_n,
  input  logic                       pipe_valid,
  input  logic                       pipe_wen,
  input  logic [ADDR_W-1:0]          pipe_waddr,
  input  logic [DATA_W-1:0]          pipe_wdata,
  output logic                       pipe_allow_in,
  input  logic                       mul_valid,
  output logic                       mul_ready,
  input  logic [ADDR_W-1:0]          mul_waddr,
  input  logic [DATA_W-1:0]          mul_wdata,
  output logic                       rf_wen,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [$clog2(Q_DEPTH):0]   mul_pending
);
  import wb_pkg::*;

  localparam int                   C_CNT_W    = $clog2(Q_DEPTH) + 1;
  localparam int                   C_WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [C_CNT_W-1:0]   C_DEPTH    = C_CNT_W'(Q_DEPTH);
  localparam logic [C_WAIT_W-1:0]  C_MAX_WAIT = C_WAIT_W'(MAX_WAIT);

  wb_state_e           state_q, state_d;
  logic [C_WAIT_W-1:0] wait_q, wait_d;
  logic                rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

  logic [ADDR_W-1:0]   w_head_waddr;
  logic [DATA_W-1:0]   w_head_wdata;
  logic                w_head_valid;
  logic [C_CNT_W-1:0]  w_count;
  logic [C_CNT_W-1:0]  w_count_next;
  logic                w_empty;
  logic                w_full;
  logic                w_enq;
  logic                w_pipe_write;
  logic                w_push_kill;
  logic                w_pop;
  logic                w_grant;
  logic [ADDR_W-1:0]   w_gaddr;
  logic [DATA_W-1:0]   w_gdata;

  assign w_empty       = (w_count == '0);
  assign w_full        = (w_count == C_DEPTH);
  assign pipe_allow_in = (state_q == NORMAL);
  assign mul_ready     = (w_count < C_DEPTH);
  assign w_enq         = mul_valid && mul_ready;
  assign w_pipe_write  = pipe_valid && pipe_allow_in && pipe_wen && (pipe_waddr != '0);
  // A pipe write is younger than any multiplier result arriving in the same cycle.
  assign w_push_kill   = w_pipe_write && (mul_waddr == pipe_waddr);
  assign w_count_next  = w_count + C_CNT_W'(w_enq) - C_CNT_W'(w_pop);

  wb_mul_queue #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .Q_DEPTH (Q_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rsta_n       (rsta_n),
    .push_i       (w_enq),
    .push_kill_i  (w_push_kill),
    .push_waddr_i (mul_waddr),
    .push_wdata_i (mul_wdata),
    .pop_i        (w_pop),
    .kill_i       (w_pipe_write),
    .kill_addr_i  (pipe_waddr),
    .head_waddr_o (w_head_waddr),
    .head_wdata_o (w_head_wdata),
    .head_valid_o (w_head_valid),
    .count_o      (w_count)
  );

  always_comb begin
    w_pop   = 1'b0;
    w_grant = 1'b0;
    w_gaddr = '0;
    w_gdata = '0;
    if ((state_q == NORMAL) && w_pipe_write) begin
      w_grant = 1'b1;
      w_gaddr = pipe_waddr;
      w_gdata = pipe_wdata;
    end else if (!w_empty) begin
      // Killed heads are retired without using the port.
      w_pop   = 1'b1;
      w_grant = w_head_valid;
      w_gaddr = w_head_waddr;
      w_gdata = w_head_wdata;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (w_empty || w_pop) begin
      wait_d = '0;
    end else if (w_head_valid && (wait_q != C_MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL: begin
        if ((w_full && w_pipe_write && !w_pop) || (wait_d == C_MAX_WAIT)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (w_count_next == '0) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    rf_wen_d   = w_grant && (w_gaddr != '0);
    rf_waddr_d = w_grant ? w_gaddr : rf_waddr_q;
    rf_wdata_d = w_grant ? w_gdata : rf_wdata_q;
  end

  always_ff @(posedge clk or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q    <= NORMAL;
      wait_q     <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen      = rf_wen_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign mul_pending = w_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_wb_port_arbiter                                                     |
// | Directed bench with a timed write scoreboard for wb_port_arbiter.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_wb_port_arbiter;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rsta_n;
  logic        pipe_valid, pipe_wen, mul_valid;
  logic [4:0]  pipe_waddr, mul_waddr;
  logic [31:0] pipe_wdata, mul_wdata;
  logic        pipe_allow_in, mul_ready, rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  mul_pending;

  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;
  exp_t sb[$];

  wb_port_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .Q_DEPTH  (2),
    .MAX_WAIT (4)
  ) dut (
    .clk           (clk),
    .rsta_n        (rsta_n),
    .pipe_valid    (pipe_valid),
    .pipe_wen      (pipe_wen),
    .pipe_waddr    (pipe_waddr),
    .pipe_wdata    (pipe_wdata),
    .pipe_allow_in (pipe_allow_in),
    .mul_valid     (mul_valid),
    .mul_ready     (mul_ready),
    .mul_waddr     (mul_waddr),
    .mul_wdata     (mul_wdata),
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .mul_pending   (mul_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Every rf write must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    if (rsta_n) begin
      if (rf_wen) begin
        if (sb.size() == 0) begin
          checks++;
          assert (rf_wen === 1'b0) else begin
            failures++;
            $error("FAIL unexpected_write: got wen=1 a=%0d d=%h at cyc %0d, want no write", rf_waddr, rf_wdata, cyc_n);
          end
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          assert (rf_waddr === e.a && rf_wdata === e.d && cyc_n === e.cyc) else begin
            failures++;
            $error("FAIL rf_write: got a=%0d d=%h cyc=%0d, want a=%0d d=%h cyc=%0d", rf_waddr, rf_wdata, cyc_n, e.a, e.d, e.cyc);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc_n) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (rf_wen === 1'b1) else begin
          failures++;
          $error("FAIL missing_write: got wen=%b, want a=%0d d=%h at cyc %0d", rf_wen, e.a, e.d, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic pv, input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    @(posedge clk);
    #1;
    pipe_valid = pv;
    pipe_wen   = pw;
    pipe_waddr = pa;
    pipe_wdata = pd;
    mul_valid  = mv;
    mul_waddr  = ma;
    mul_wdata  = md;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc_n + 1;
    e.a   = a;
    e.d   = d;
    sb.push_back(e);
  endtask

  task automatic chk_ctl(input string tag, input logic ea, input logic er, input logic [1:0] ep);
    #1;
    checks++;
    assert (pipe_allow_in === ea) else begin
      failures++;
      $error("FAIL %s.allow_in: got %b want %b", tag, pipe_allow_in, ea);
    end
    checks++;
    assert (mul_ready === er) else begin
      failures++;
      $error("FAIL %s.mul_ready: got %b want %b", tag, mul_ready, er);
    end
    checks++;
    assert (mul_pending === ep) else begin
      failures++;
      $error("FAIL %s.pending: got %0d want %0d", tag, mul_pending, ep);
    end
  endtask

  initial begin
    rsta_n = 1'b0;
    pipe_valid = 1'b0; pipe_wen = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    mul_valid = 1'b0; mul_waddr = '0; mul_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (rf_wen === 1'b0 && rf_waddr === 5'd0 && rf_wdata === 32'd0) else begin
      failures++;
      $error("FAIL reset_rf: got wen=%b a=%0d d=%h want 0/0/0", rf_wen, rf_waddr, rf_wdata);
    end
    chk_ctl("reset", 1'b1, 1'b1, 2'd0);
    rsta_n = 1'b1;

    // Pipe only
    drive(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0); exp_wr(5'd5, 32'h1234);
    chk_ctl("pipe_only", 1'b1, 1'b1, 2'd0);
    idle(); chk_ctl("pipe_only_after", 1'b1, 1'b1, 2'd0);

    // Free-slot fill
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
    chk_ctl("fill_enq", 1'b1, 1'b1, 2'd0);
    drive(1'b1, 1'b0, 5'd2, 32'hDEAD, 1'b0, 5'd0, 32'd0); exp_wr(5'd7, 32'hAA);
    chk_ctl("fill_slot", 1'b1, 1'b1, 2'd1);
    idle(); chk_ctl("fill_done", 1'b1, 1'b1, 2'd0);

    // Starvation drain
    drive(1'b1, 1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h33); exp_wr(5'd1, 32'h100);
    chk_ctl("starve_s0", 1'b1, 1'b1, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 5'd1, 32'h100 + i, 1'b0, 5'd0, 32'd0); exp_wr(5'd1, 32'h100 + i);
      chk_ctl("starve_bypass", 1'b1, 1'b1, 2'd1);
    end
    drive(1'b1, 1'b1, 5'd1, 32'h1FF, 1'b0, 5'd0, 32'd0); exp_wr(5'd3, 32'h33);
    chk_ctl("starve_drain", 1'b0, 1'b1, 2'd1);
    idle(); chk_ctl("starve_resume", 1'b1, 1'b1, 2'd0);

    // Full queue
    drive(1'b1, 1'b1, 5'd2, 32'h200, 1'b1, 5'd10, 32'hA0); exp_wr(5'd2, 32'h200);
    chk_ctl("full_f0", 1'b1, 1'b1, 2'd0);
    drive(1'b1, 1'b1, 5'd2, 32'h201, 1'b1, 5'd11, 32'hB0); exp_wr(5'd2, 32'h201);
    chk_ctl("full_f1", 1'b1, 1'b1, 2'd1);
    drive(1'b1, 1'b1, 5'd2, 32'h202, 1'b1, 5'd12, 32'hC0); exp_wr(5'd2, 32'h202);
    chk_ctl("full_f2", 1'b1, 1'b0, 2'd2);
    drive(1'b1, 1'b1, 5'd2, 32'h203, 1'b1, 5'd12, 32'hC0); exp_wr(5'd10, 32'hA0);
    chk_ctl("full_drain0", 1'b0, 1'b0, 2'd2);
    drive(1'b1, 1'b1, 5'd2, 32'h204, 1'b0, 5'd0, 32'd0); exp_wr(5'd11, 32'hB0);
    chk_ctl("full_drain1", 1'b0, 1'b1, 2'd1);
    idle(); chk_ctl("full_resume", 1'b1, 1'b1, 2'd0);

    // WAW kill on a queued entry, then on a same-cycle enqueue
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h11);
    chk_ctl("waw_enq", 1'b1, 1'b1, 2'd0);
    drive(1'b1, 1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0); exp_wr(5'd9, 32'h22);
    chk_ctl("waw_pipe", 1'b1, 1'b1, 2'd1);
    idle(); chk_ctl("waw_killpop", 1'b1, 1'b1, 2'd1);
    idle(); chk_ctl("waw_empty", 1'b1, 1'b1, 2'd0);
    drive(1'b1, 1'b1, 5'd9, 32'h44, 1'b1, 5'd9, 32'h33); exp_wr(5'd9, 32'h44);
    chk_ctl("waw_same", 1'b1, 1'b1, 2'd0);
    idle(); chk_ctl("waw_same_pop", 1'b1, 1'b1, 2'd1);
    idle(); chk_ctl("waw_same_empty", 1'b1, 1'b1, 2'd0);

    // Address-0 results from either side never write
    drive(1'b1, 1'b1, 5'd0, 32'h66, 1'b1, 5'd0, 32'h55);
    chk_ctl("zero_enq", 1'b1, 1'b1, 2'd0);
    idle(); chk_ctl("zero_pop", 1'b1, 1'b1, 2'd1);
    idle(); chk_ctl("zero_empty", 1'b1, 1'b1, 2'd0);

    // Reset mid-drain
    drive(1'b1, 1'b1, 5'd4, 32'h400, 1'b1, 5'd20, 32'hD0); exp_wr(5'd4, 32'h400);
    chk_ctl("rst_r0", 1'b1, 1'b1, 2'd0);
    drive(1'b1, 1'b1, 5'd4, 32'h401, 1'b1, 5'd21, 32'hD1); exp_wr(5'd4, 32'h401);
    chk_ctl("rst_r1", 1'b1, 1'b1, 2'd1);
    drive(1'b1, 1'b1, 5'd4, 32'h402, 1'b0, 5'd0, 32'd0); exp_wr(5'd4, 32'h402);
    chk_ctl("rst_r2", 1'b1, 1'b0, 2'd2);
    idle(); chk_ctl("rst_drain", 1'b0, 1'b0, 2'd2);
    @(negedge clk);
    #1;
    rsta_n = 1'b0;
    #1;
    checks++;
    assert (rf_wen === 1'b0) else begin
      failures++;
      $error("FAIL rst_mid.rf_wen: got %b want 0", rf_wen);
    end
    chk_ctl("rst_mid", 1'b1, 1'b1, 2'd0);
    @(posedge clk);
    #1;
    rsta_n = 1'b1;
    repeat (4) idle();
    chk_ctl("rst_after", 1'b1, 1'b1, 2'd0);
    @(negedge clk);
    #1;
    checks++;
    assert (sb.size() === 0) else begin
      failures++;
      $error("FAIL scoreboard_drained: got %0d left want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
